// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings, FSM state type and operand-signedness helpers for the
// iterative RV32M multiply/divide unit.
package alu_muldiv_seq_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [4:0] ALU_MUL    = 5'b11000;
    localparam logic [4:0] ALU_MULH   = 5'b11001;
    localparam logic [4:0] ALU_MULHSU = 5'b11010;
    localparam logic [4:0] ALU_MULHU  = 5'b11011;
    localparam logic [4:0] ALU_DIV    = 5'b11100;
    localparam logic [4:0] ALU_DIVU   = 5'b11101;
    localparam logic [4:0] ALU_REM    = 5'b11110;
    localparam logic [4:0] ALU_REMU   = 5'b11111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    function automatic logic is_m_op(input logic [4:0] op);
        return (op[4:3] == 2'b11);
    endfunction

    function automatic logic op1_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULHU, F3_DIVU, F3_REMU: s = 1'b0;
            default:                    s = 1'b1;
        endcase
        return s;
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULHSU, F3_MULHU, F3_DIVU, F3_REMU: s = 1'b0;
            default:                               s = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_post_fix.sv
// Combinational result finishing: sign correction, product half select and
// the divide-by-zero / signed-overflow fixed results.
module alu_muldiv_seq_post_fix
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] op1,
    input  logic             neg_res,
    input  logic             neg_rem,
    input  logic             div0,
    input  logic             ovf,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0]   ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ZERO2   = {(2*WIDTH){1'b0}};

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // hi/lo hold product high/low for multiplies, remainder/quotient for divides
    always_comb begin
        prod_s     = {hi, lo};
        prod_fix_s = neg_res ? (ZERO2 - prod_s) : prod_s;
        quo_s      = neg_res ? (ZERO - lo) : lo;
        rem_s      = neg_rem ? (ZERO - hi) : hi;
        result     = ZERO;
        case (funct3)
            F3_MUL: result = prod_fix_s[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix_s[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU: begin
                if (div0) begin
                    result = ONES;
                end else if (ovf) begin
                    result = MIN_NEG;
                end else begin
                    result = quo_s;
                end
            end
            F3_REM, F3_REMU: begin
                if (div0) begin
                    result = op1;
                end else if (ovf) begin
                    result = ZERO;
                end else begin
                    result = rem_s;
                end
            end
            default: result = ZERO;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring
// divide step per clock, with a two-edge fast path for div-by-zero/overflow.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       f3_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] op1_r;
    logic             neg_res_r;
    logic             neg_rem_r;
    logic             div0_r;
    logic             ovf_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             is_div_s;
    logic             sign1_s;
    logic             sign2_s;
    logic [WIDTH-1:0] mag1_s;
    logic [WIDTH-1:0] mag2_s;
    logic             div0_s;
    logic             ovf_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] hi_next_s;
    logic [WIDTH-1:0] lo_next_s;
    logic [WIDTH-1:0] post_fix_s;

    // Launch qualification and operand-to-magnitude conversion
    always_comb begin
        accept_s = (state_r == ST_IDLE) && start && is_m_op(alu_op) && !kill;
        is_div_s = alu_op[2];
        sign1_s  = op1_signed(alu_op[2:0]) && op1[WIDTH-1];
        sign2_s  = op2_signed(alu_op[2:0]) && op2[WIDTH-1];
        mag1_s   = sign1_s ? (ZERO - op1) : op1;
        mag2_s   = sign2_s ? (ZERO - op2) : op2;
        div0_s   = is_div_s && (op2 == ZERO);
        ovf_s    = is_div_s && op1_signed(alu_op[2:0]) && (op1 == MIN_NEG) && (op2 == ONES);
    end

    // One iteration: lo is the multiplier (mul) or dividend/quotient (div)
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {1'b0, ZERO});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        if (f3_r[2]) begin
            if (!div_diff_s[WIDTH]) begin
                hi_next_s = div_diff_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_next_s = div_shift_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next_s = mul_sum_s[WIDTH:1];
            lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    alu_muldiv_seq_post_fix #(
        .WIDTH (WIDTH)
    ) u_post_fix (
        .funct3  (f3_r),
        .hi      (hi_r),
        .lo      (lo_r),
        .op1     (op1_r),
        .neg_res (neg_res_r),
        .neg_rem (neg_rem_r),
        .div0    (div0_r),
        .ovf     (ovf_r),
        .result  (post_fix_s)
    );

    // Control FSM with counter, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            f3_r      <= 3'b000;
            hi_r      <= ZERO;
            lo_r      <= ZERO;
            b_r       <= ZERO;
            op1_r     <= ZERO;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
            result_r  <= ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        f3_r      <= alu_op[2:0];
                        op1_r     <= op1;
                        neg_res_r <= sign1_s ^ sign2_s;
                        neg_rem_r <= sign1_s;
                        div0_r    <= div0_s;
                        ovf_r     <= ovf_s;
                        hi_r      <= ZERO;
                        lo_r      <= is_div_s ? mag1_s : mag2_s;
                        b_r       <= is_div_s ? mag2_s : mag1_s;
                        cnt_r     <= CNT_ZERO;
                        busy_r    <= 1'b1;
                        state_r   <= (div0_s || ovf_s) ? ST_FIN : ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        hi_r <= hi_next_s;
                        lo_r <= lo_next_s;
                        if (cnt_r == CNT_LAST) begin
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_FIN;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_FIN: begin
                    if (kill) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        result_r <= post_fix_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: expected results are queued at launch
// and popped when DONE is seen; latencies are counted in edges after accept.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [4:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    alu_muldiv_seq #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .alu_op (alu_op),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic in 64-bit, independent of the iterative datapath
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        up;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = 32'h0;
        case (op)
            ALU_MUL:    begin sp = sa * sb; r = sp[31:0]; end
            ALU_MULH:   begin sp = sa * sb; r = sp[63:32]; end
            ALU_MULHSU: begin sp = sa * $signed(ub); r = sp[63:32]; end
            ALU_MULHU:  begin up = ua * ub; r = up[63:32]; end
            ALU_DIV: begin
                if (b == 32'h0) r = ALL_ONES;
                else if (a == MIN_NEG && b == ALL_ONES) r = MIN_NEG;
                else begin sp = sa / sb; r = sp[31:0]; end
            end
            ALU_DIVU: begin
                if (b == 32'h0) r = ALL_ONES;
                else begin up = ua / ub; r = up[31:0]; end
            end
            ALU_REM: begin
                if (b == 32'h0) r = a;
                else if (a == MIN_NEG && b == ALL_ONES) r = 32'h0;
                else begin sp = sa % sb; r = sp[31:0]; end
            end
            ALU_REMU: begin
                if (b == 32'h0) r = a;
                else begin up = ua % ub; r = up[31:0]; end
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'h0 || (!op[0] && a == MIN_NEG && b == ALL_ONES))) return 1;
        return 33;
    endfunction

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles);
        int b0;
        int bc;
        start = 1'b1; alu_op = op; op1 = a; op2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        b0 = busy ? 1 : 0;
        wait_done(lat, bc);
        busy_cycles = bc + b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; kill = 1'b0; alu_op = 5'b00000; op1 = 32'h0; op2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want %h", result, 32'h0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul;
        int lat;
        int bc;
        logic [31:0] e;
        exp_q.push_back(32'hFFFF_FFEB);
        run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, lat, bc);
        e = exp_q.pop_front();
        n_checks++; if (result !== e) begin n_fail++; $display("FAIL mul_result: got %h want %h", result, e); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_done: got %b want 0", busy); end
        last_exp = e;
    endtask

    task automatic test_mul_high;
        vec_t v[3];
        int lat;
        int bc;
        logic [31:0] e;
        v = '{'{ALU_MULHU,  ALL_ONES, ALL_ONES, 32'hFFFF_FFFE, 8'd33},
              '{ALU_MULH,   ALL_ONES, ALL_ONES, 32'h0000_0000, 8'd33},
              '{ALU_MULHSU, ALL_ONES, 32'd2,    32'hFFFF_FFFF, 8'd33}};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(v[i].exp);
            run_op(v[i].op, v[i].a, v[i].b, lat, bc);
            e = exp_q.pop_front();
            n_checks++; if (result !== e) begin n_fail++; $display("FAIL mulh_result[%0d]: got %h want %h", i, result, e); end
            n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL mulh_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
            last_exp = e;
        end
    endtask

    task automatic test_div_rem;
        vec_t v[4];
        int lat;
        int bc;
        logic [31:0] e;
        v = '{'{ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 8'd33},
              '{ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 8'd33},
              '{ALU_DIVU, 32'd100,       32'd7, 32'd14,        8'd33},
              '{ALU_REMU, 32'd100,       32'd7, 32'd2,         8'd33}};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(v[i].exp);
            run_op(v[i].op, v[i].a, v[i].b, lat, bc);
            e = exp_q.pop_front();
            n_checks++; if (result !== e) begin n_fail++; $display("FAIL divrem_result[%0d]: got %h want %h", i, result, e); end
            n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL divrem_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
            last_exp = e;
        end
    endtask

    // Fast path: accept edge plus one FIN edge, so DONE follows the first edge after accept
    task automatic test_fast_path;
        vec_t v[4];
        int lat;
        int bc;
        logic [31:0] e;
        v = '{'{ALU_DIVU, 32'd5,   32'd0,    ALL_ONES, 8'd1},
              '{ALU_REMU, 32'd5,   32'd0,    32'd5,    8'd1},
              '{ALU_DIV,  MIN_NEG, ALL_ONES, MIN_NEG,  8'd1},
              '{ALU_REM,  MIN_NEG, ALL_ONES, 32'h0,    8'd1}};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(v[i].exp);
            run_op(v[i].op, v[i].a, v[i].b, lat, bc);
            e = exp_q.pop_front();
            n_checks++; if (result !== e) begin n_fail++; $display("FAIL fast_result[%0d]: got %h want %h", i, result, e); end
            n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL fast_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
            n_checks++; if (bc != 1) begin n_fail++; $display("FAIL fast_busy_cycles[%0d]: got %0d want 1", i, bc); end
            last_exp = e;
        end
    endtask

    task automatic test_random;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          sel;
        int          lat;
        int          bc;
        int          el;
        for (int i = 0; i < 24; i++) begin
            f3  = 3'($urandom_range(0, 7));
            op  = {2'b11, f3};
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = MIN_NEG; b = ALL_ONES; end
            else if (sel < 5) b = 32'($urandom_range(1, 100));
            else b = $urandom;
            el = model_lat(op, a, b);
            exp_q.push_back(model(op, a, b));
            run_op(op, a, b, lat, bc);
            e = exp_q.pop_front();
            n_checks++; if (result !== e) begin n_fail++; $display("FAIL rand_result[%0d] op=%b a=%h b=%h: got %h want %h", i, op, a, b, result, e); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, el); end
            last_exp = e;
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int bc;
        logic [31:0] e;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'hFFFF_FFFE);
        start = 1'b1; alu_op = ALU_DIVU; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1;
        alu_op = ALU_MULHU; op1 = ALL_ONES; op2 = ALL_ONES;
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++; if (result !== e) begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", result, e); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 33", lat); end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: busy got %b want 1", busy); end
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++; if (result !== e) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", result, e); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        last_exp = e;
    endtask

    task automatic test_kill;
        int n_done;
        start = 1'b1; alu_op = ALU_MUL; op1 = 32'd3; op2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b want 0", busy); end
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL kill_no_done: got %0d pulses want 0", n_done); end
        n_checks++; if (result !== last_exp) begin n_fail++; $display("FAIL kill_result_held: got %h want %h", result, last_exp); end
    endtask

    task automatic test_reset_mid;
        int n_done;
        start = 1'b1; alu_op = ALU_DIV; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want %h", result, 32'h0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n_done); end
        last_exp = 32'h0;
    endtask

    task automatic test_illegal_op;
        int n_done;
        int n_busy;
        start = 1'b1; alu_op = 5'b00000; op1 = 32'd9; op2 = 32'd9;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        start = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        n_checks++; if (n_busy != 0) begin n_fail++; $display("FAIL illegal_busy: got %0d cycles want 0", n_busy); end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL illegal_done: got %0d pulses want 0", n_done); end
        n_checks++; if (result !== last_exp) begin n_fail++; $display("FAIL illegal_result_held: got %h want %h", result, last_exp); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = 32'h0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div_rem();
        test_fast_path();
        test_random();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_illegal_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
